winograd_result_streamer: RTL

Downstream stage of `winograd_conv_10x12`. It detects completion of a convolution and snapshots the 8x10 parallel result array into a local buffer. It then streams the 80 elements out in row-major order over a valid/ready interface, one element per accepted beat. Buffering the snapshot releases the convolution engine so it can start its next job while streaming is in progress.

---
 rtl/winograd_result_streamer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/winograd_result_streamer.sv
// winograd_result_streamer
// Snapshots the ROWS x COLS result array of winograd_conv_10x12 on the rising
// edge of conv_done and streams it out row-major over a valid/ready port.
// Snapshotting frees the convolution engine to start its next job while the
// previous frame is still draining.
// Optional feature: define WINOGRAD_STREAM_RELU_EN to clamp negative elements
// to zero as they are captured. Without it, data passes through bit-exact.
module winograd_result_streamer #(
    parameter int ROWS   = 8,
    parameter int COLS   = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              conv_done,
    input  logic [DATA_W-1:0] conv_result [0:ROWS-1][0:COLS-1],
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_row_last,
    output logic              m_last,
    output logic              busy,
    output logic              overrun
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    state_t            state;
    logic              done_q;
    logic [RW-1:0]     row;
    logic [CW-1:0]     col;
    logic [DATA_W-1:0] frame_buf [0:ROWS-1][0:COLS-1];

    logic cap_evt;
    logic handshake;
    logic at_row_end;
    logic at_last;
    logic capture;

    // Value written into the snapshot buffer for one element.
    function automatic logic [DATA_W-1:0] store_val(input logic [DATA_W-1:0] x);
`ifdef WINOGRAD_STREAM_RELU_EN
        return x[DATA_W-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    // Event decode: conv_done is a level, so only its rising edge starts a frame.
    // A capture happens from idle, or on the final handshake for a gapless restart.
    always_comb begin
        cap_evt    = conv_done & ~done_q;
        handshake  = m_valid & m_ready;
        at_row_end = (col == COL_LAST);
        at_last    = at_row_end && (row == ROW_LAST);
        capture    = cap_evt && ((state == S_IDLE) || (handshake && at_last));
    end

    // Output view of the buffer; everything reads zero while no element is offered.
    always_comb begin
        m_valid    = (state == S_STREAM);
        m_data     = m_valid ? frame_buf[row][col] : '0;
        m_row_last = m_valid & at_row_end;
        m_last     = m_valid & at_last;
    end

    // Snapshot buffer: loads the whole result array in one cycle on capture.
    // NOTE: the buffer is explicitly reset so a frame aborted by reset can never
    // leak stale data; this costs a reset net on every buffer flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    frame_buf[r][c] <= '0;
        end else if (capture) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    frame_buf[r][c] <= store_val(conv_result[r][c]);
        end
    end

    // Streaming FSM: index walk, frame boundaries, busy and overrun flags.
    // NOTE: all state here uses non-blocking assignments so every branch sees
    // the pre-edge values of row/col/state, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            done_q  <= 1'b0;
            row     <= '0;
            col     <= '0;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            done_q  <= conv_done;
            overrun <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cap_evt) begin
                        state <= S_STREAM;
                        busy  <= 1'b1;
                        row   <= '0;
                        col   <= '0;
                    end
                end
                S_STREAM: begin
                    if (handshake) begin
                        if (at_last) begin
                            row <= '0;
                            col <= '0;
                            if (!cap_evt) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        end else if (at_row_end) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                    if (cap_evt && !(handshake && at_last))
                        overrun <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
